// File: rtl/reg_window_ctrl.sv
// Register-window controller: owns cwp, sequences CALL/RET, and
// spills/fills one 2-reg pair to a memory stack when windows collide.
//
// Ports: clk, rst_n (async low); call/ret requests; window (cwp);
// stall; rf_rd_addr/rf_rd_data (spill read); rf_wr_en/addr/data (fill);
// mem_req/we/addr/wdata/rdata/ack (spill stack); win_err (sticky flag).
// Optional macro REGWIN_TRAP_EN: a CALL at max depth or a RET at depth 0
// sets win_err until reset; when undefined win_err is tied 0.
module reg_window_ctrl #(
  parameter logic [15:0] SPILL_BASE = 16'hFF00,
  parameter int          DEPTH_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        call,
  input  logic        ret,
  output logic [1:0]  window,
  output logic        stall,
  output logic [2:0]  rf_rd_addr,
  input  logic [15:0] rf_rd_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        win_err
);

  typedef enum logic [2:0] {
    IDLE,
    SPILL_LO,
    SPILL_HI,
    FILL_HI,
    FILL_LO
  } state_t;

  localparam logic [DEPTH_BITS-1:0] D_MAX = '1;
  localparam logic [DEPTH_BITS-1:0] D_ONE = 1;

  state_t                state;
  logic [DEPTH_BITS-1:0] depth;
  logic [1:0]            resident;
  logic [15:0]           sp;

  logic       idle;
  logic       call_ok;
  logic       ret_ok;
  logic       spill_go;
  logic       fill_go;
  logic       spilling;
  logic       filling;
  logic [1:0] w_up2;
  logic [1:0] w_dn1;

  assign idle     = (state == IDLE);
  assign spilling = (state == SPILL_LO) || (state == SPILL_HI);
  assign filling  = (state == FILL_HI) || (state == FILL_LO);

  assign call_ok  = idle && call && !ret && (depth != D_MAX);
  assign ret_ok   = idle && ret && !call && (depth != '0);

  // A CALL with three live frames would overwrite the oldest
  // frame's low pair; a RET with one live frame finds the
  // caller's low pair already spilled.
  assign spill_go = call_ok && (resident == 2'd3);
  assign fill_go  = ret_ok && (resident == 2'd1);

  assign stall    = !idle || spill_go || fill_go;

  // Pair owned by window+2 (oldest frame) / window-1 (caller).
  assign w_up2    = window + 2'd2;
  assign w_dn1    = window - 2'd1;

  assign mem_wdata  = spilling ? rf_rd_data : '0;
  assign rf_wr_en   = filling && mem_ack;
  assign rf_wr_data = rf_wr_en ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      window     <= '0;
      depth      <= '0;
      resident   <= 2'd1;
      sp         <= SPILL_BASE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      rf_rd_addr <= '0;
      rf_wr_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (spill_go) begin
            state      <= SPILL_LO;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= sp;
            rf_rd_addr <= {w_up2, 1'b0};
          end else if (call_ok) begin
            window   <= window + 2'd1;
            depth    <= depth + D_ONE;
            resident <= resident + 2'd1;
          end else if (fill_go) begin
            // LIFO: the high reg went out last, so it returns first.
            state      <= FILL_HI;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= sp - 16'd1;
            rf_wr_addr <= {w_dn1, 1'b1};
          end else if (ret_ok) begin
            window   <= w_dn1;
            depth    <= depth - D_ONE;
            resident <= resident - 2'd1;
          end
        end
        SPILL_LO: begin
          if (mem_ack) begin
            sp         <= sp + 16'd1;
            mem_addr   <= sp + 16'd1;
            rf_rd_addr <= {rf_rd_addr[2:1], 1'b1};
            state      <= SPILL_HI;
          end
        end
        SPILL_HI: begin
          if (mem_ack) begin
            sp         <= sp + 16'd1;
            window     <= window + 2'd1;
            depth      <= depth + D_ONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            rf_rd_addr <= '0;
            state      <= IDLE;
          end
        end
        FILL_HI: begin
          if (mem_ack) begin
            sp         <= sp - 16'd1;
            mem_addr   <= sp - 16'd2;
            rf_wr_addr <= {rf_wr_addr[2:1], 1'b0};
            state      <= FILL_LO;
          end
        end
        FILL_LO: begin
          if (mem_ack) begin
            sp       <= sp - 16'd1;
            window   <= w_dn1;
            depth    <= depth - D_ONE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REGWIN_TRAP_EN
  logic bad_req;
  logic err_q;

  assign bad_req = idle && (
    (call && !ret && (depth == D_MAX)) ||
    (ret && !call && (depth == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bad_req) begin
      err_q <= 1'b1;
    end
  end

  assign win_err = err_q;
`else
  assign win_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Scoreboard bench for reg_window_ctrl: directed scenarios then
// random CALL/RET traffic against a frame-stack reference model.
module tb_reg_window_ctrl;

`ifdef REGWIN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int BASE = 16'hFF00;
  localparam int MAXD = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [1:0]  window;
  logic        stall;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        win_err;

  always #5 clk = ~clk;

  reg_window_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call       (call),
    .ret        (ret),
    .window     (window),
    .stall      (stall),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .win_err    (win_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
  endtask

  // Register file owned by the bench (core side).
  logic [15:0] regs[8];
  logic [15:0] load_vals[8];
  logic        load = 1'b0;

  assign rf_rd_data = regs[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
    else if (load) for (int i = 0; i < 8; i++) regs[i] <= load_vals[i];
  end

  task automatic load_regs(input bit rnd, input logic [15:0] r0,
                           input logic [15:0] r1);
    for (int i = 0; i < 8; i++) load_vals[i] = 16'($urandom);
    if (!rnd) begin
      load_vals[0] = r0;
      load_vals[1] = r1;
    end
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Memory responder: lat<0 picks a random 0..3 wait per request.
  logic [15:0] mem[logic [15:0]];
  int lat = -1;
  int dly = 0;
  bit busy = 1'b0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          dly = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        end
        if (dly == 0) begin
          mem_ack = 1'b1;
          busy = 1'b0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
        end else begin
          dly--;
        end
      end
    end
  end

  // Scoreboard queues.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } mtx_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } rtx_t;

  mtx_t mq[$];
  rtx_t rq[$];
  int   req_cycles = 0;

  initial begin
    logic        pv_req;
    logic        pv_ack;
    logic        pv_we;
    logic [15:0] pv_addr;
    logic [15:0] pv_wdata;
    mtx_t        me;
    rtx_t        re;
    pv_req = 1'b0;
    pv_ack = 1'b0;
    pv_we = 1'b0;
    pv_addr = '0;
    pv_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_req = 1'b0;
      end else begin
        if (mem_req) begin
          req_cycles++;
          chk("stall_with_req", stall, 1'b1);
        end
        if (pv_req && !pv_ack) begin
          chk("req_held", mem_req, 1'b1);
          chk("addr_held", mem_addr, pv_addr);
          chk("we_held", mem_we, pv_we);
          if (pv_we) chk("wdata_held", mem_wdata, pv_wdata);
        end
        if (mem_req && mem_ack) begin
          if (mq.size() == 0) begin
            bad("mem_unexpected", mem_addr, 0);
          end else begin
            me = mq.pop_front();
            chk("mem_we", mem_we, me.we);
            chk("mem_addr", mem_addr, me.addr);
            if (me.we) chk("mem_wdata", mem_wdata, me.data);
          end
        end
        if (rf_wr_en) begin
          if (rq.size() == 0) begin
            bad("rf_unexpected", rf_wr_addr, 0);
          end else begin
            re = rq.pop_front();
            chk("rf_wr_addr", rf_wr_addr, re.addr);
            chk("rf_wr_data", rf_wr_data, re.data);
          end
        end
        pv_req = mem_req;
        pv_ack = mem_ack;
        pv_we = mem_we;
        pv_addr = mem_addr;
        pv_wdata = mem_wdata;
      end
    end
  end

  // Reference model: live-frame count plus a LIFO of spilled pairs.
  int          m_win;
  int          m_depth;
  int          m_res;
  int          m_sp;
  bit          m_err;
  logic [15:0] stk_lo[$];
  logic [15:0] stk_hi[$];

  task automatic model_reset();
    m_win = 0;
    m_depth = 0;
    m_res = 1;
    m_sp = BASE;
    m_err = 1'b0;
    stk_lo.delete();
    stk_hi.delete();
    mq.delete();
    rq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_window", window, 2'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_rf_wr_en", rf_wr_en, 1'b0);
    chk("rst_rf_rd_addr", rf_rd_addr, 3'd0);
    chk("rst_win_err", win_err, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model update for one request; returns whether stall is expected.
  task automatic model_op(input bit c, input bit r, output bit exp_stall);
    mtx_t e;
    rtx_t w;
    int   p;
    exp_stall = 1'b0;
    if (c && !r) begin
      if (m_depth == MAXD) begin
        m_err = m_err | TRAP;
      end else if (m_res < 3) begin
        m_win = (m_win + 1) % 4;
        m_depth++;
        m_res++;
      end else begin
        p = (2 * (m_win + 2)) % 8;
        e.we = 1'b1;
        e.addr = 16'(m_sp);
        e.data = regs[p];
        mq.push_back(e);
        e.addr = 16'(m_sp + 1);
        e.data = regs[p + 1];
        mq.push_back(e);
        stk_lo.push_back(regs[p]);
        stk_hi.push_back(regs[p + 1]);
        m_sp += 2;
        m_win = (m_win + 1) % 4;
        m_depth++;
        exp_stall = 1'b1;
      end
    end else if (r && !c) begin
      if (m_depth == 0) begin
        m_err = m_err | TRAP;
      end else if (m_res > 1) begin
        m_win = (m_win + 3) % 4;
        m_depth--;
        m_res--;
      end else begin
        p = (2 * (m_win + 3)) % 8;
        e.we = 1'b0;
        e.data = '0;
        e.addr = 16'(m_sp - 1);
        mq.push_back(e);
        e.addr = 16'(m_sp - 2);
        mq.push_back(e);
        w.addr = 3'(p + 1);
        w.data = stk_hi.pop_back();
        rq.push_back(w);
        w.addr = 3'(p);
        w.data = stk_lo.pop_back();
        rq.push_back(w);
        m_sp -= 2;
        m_win = (m_win + 3) % 4;
        m_depth--;
        exp_stall = 1'b1;
      end
    end
  endtask

  task automatic do_op(input bit c, input bit r);
    bit es;
    int n;
    model_op(c, r, es);
    @(negedge clk);
    call = c;
    ret = r;
    #1 chk("stall_on_request", stall, es);
    @(posedge clk);
    #1;
    call = 1'b0;
    ret = 1'b0;
    n = 0;
    while (stall && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (stall) bad("stall_timeout", n, 300);
    chk("window", window, 32'(m_win));
    chk("win_err", win_err, m_err);
  endtask

  initial begin
    int  n;
    int  k;
    bit  es;
    model_reset();
    load_regs(1'b1, '0, '0);
    do_reset();

    // Two CALLs fit without spilling.
    req_cycles = 0;
    load_regs(1'b1, '0, '0);
    do_op(1'b1, 1'b0);
    do_op(1'b1, 1'b0);
    chk("t1_window", window, 2'd2);
    chk("t1_no_mem_req", req_cycles, 0);

    // Third CALL spills r0/r1.
    load_regs(1'b0, 16'h1111, 16'h2222);
    do_op(1'b1, 1'b0);
    chk("t2_window", window, 2'd3);
    chk("t2_mem_ff00", mem[16'hFF00], 16'h1111);
    chk("t2_mem_ff01", mem[16'hFF01], 16'h2222);

    // Unwind: two plain RETs, then a fill into window 0.
    load_regs(1'b1, '0, '0);
    do_op(1'b0, 1'b1);
    chk("t3_ret1_window", window, 2'd2);
    do_op(1'b0, 1'b1);
    do_op(1'b0, 1'b1);
    chk("t3_r0", regs[0], 16'h1111);
    chk("t3_r1", regs[1], 16'h2222);
    chk("t3_window", window, 2'd0);

    // Slow memory: five-cycle acks across a full spill.
    lat = 5;
    for (int i = 0; i < 3; i++) begin
      load_regs(1'b1, '0, '0);
      do_op(1'b1, 1'b0);
    end
    lat = -1;

    // Reset while the high half of a spill is outstanding.
    lat = 30;
    load_regs(1'b1, '0, '0);
    model_op(1'b1, 1'b0, es);
    k = m_sp - 1;
    @(negedge clk);
    call = 1'b1;
    @(posedge clk);
    #1 call = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 16'(k)) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 200) bad("t5_spill_hi_timeout", n, 200);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_window", window, 2'd0);
    chk("t5_stall", stall, 1'b0);
    chk("t5_mem_req", mem_req, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;

    // RET at depth 0 is refused.
    do_op(1'b0, 1'b1);
    chk("t6_window", window, 2'd0);
    chk("t6_win_err", win_err, TRAP);

    // Climb past max depth, spill base restarts at BASE after reset.
    for (int i = 0; i < MAXD + 2; i++) begin
      load_regs(1'b1, '0, '0);
      do_op(1'b1, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      load_regs(1'b1, '0, '0);
      k = int'($urandom_range(0, 9));
      if (k < 4) do_op(1'b1, 1'b0);
      else if (k < 8) do_op(1'b0, 1'b1);
      else if (k == 8) do_op(1'b1, 1'b1);
      else do_op(1'b0, 1'b0);
    end

    repeat (4) @(posedge clk);
    chk("mem_queue_drained", mq.size(), 0);
    chk("rf_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
